// File: rtl/huff_len_hist.sv
// Code-length histogram and canonical first-code generator for the Deflate
// decoder: reads NUM_SYMS lengths from RAM, counts them, derives next_code, validates the code.
module huff_len_hist #(
  parameter int LEN_BIT   = 4,
  parameter int MAX_LEN   = 15,
  parameter int NUM_SYMS  = 19,
  parameter int ADDR_BIT  = 9,
  parameter int COUNT_BIT = 9,
  parameter int RD_LAT    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BIT-1:0]  base_addr,
  output logic                 mem_en,
  output logic [ADDR_BIT-1:0]  mem_addr,
  input  logic [LEN_BIT-1:0]   mem_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic                 incomplete,
  output logic [3:0]           max_len,
  input  logic [3:0]           query_len,
  output logic [COUNT_BIT-1:0] query_count,
  output logic [MAX_LEN:0]     query_code
);

  localparam int CW = MAX_LEN + 1;
  localparam int SW = MAX_LEN + COUNT_BIT + 2;
  localparam int TW = $clog2(NUM_SYMS + RD_LAT + MAX_LEN + 2);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_CODE, S_FIN} state_t;

  // Canonical code step: the first code of length L from the code of L-1 and its count.
  function automatic logic [CW-1:0] canon_step(input logic [CW-1:0] code,
                                               input logic [COUNT_BIT-1:0] cnt_prev);
    logic [SW-1:0] w;
    w = (SW'(code) + SW'(cnt_prev)) << 1;
    return CW'(w);
  endfunction

  function automatic logic over_sub(input logic [CW-1:0] code,
                                    input logic [COUNT_BIT-1:0] cnt_cur,
                                    input logic [TW-1:0] len);
    return (SW'(code) + SW'(cnt_cur)) > (SW'(1) << len);
  endfunction

  state_t                           state_q, state_d;
  logic [TW-1:0]                    cnt_q, cnt_d;
  logic [ADDR_BIT-1:0]              base_q, base_d;
  logic [RD_LAT-1:0]                vld_q, vld_d;
  logic [MAX_LEN:0][COUNT_BIT-1:0]  bl_count_q, bl_count_d;
  logic [MAX_LEN:1][CW-1:0]         next_code_q, next_code_d;
  logic [CW-1:0]                    code_q, code_d;
  logic                             busy_q, busy_d, done_q, done_d;
  logic                             error_q, error_d, incomplete_q, incomplete_d;
  logic [1:0]                       err_code_q, err_code_d;
  logic [3:0]                       max_len_q, max_len_d;
  logic [COUNT_BIT-1:0]             cnt_prev, cnt_cur;

  assign mem_en     = (state_q == S_READ);
  assign mem_addr   = mem_en ? base_q + ADDR_BIT'(cnt_q) : '0;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;
  assign incomplete = incomplete_q;
  assign max_len    = max_len_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    bl_count_d   = bl_count_q;
    next_code_d  = next_code_q;
    code_d       = code_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    err_code_d   = err_code_q;
    incomplete_d = incomplete_q;
    max_len_d    = max_len_q;
    cnt_prev     = '0;
    cnt_cur      = '0;
    // Tag returning RAM data: bit 0 is the enable just issued, the top bit lines up with mem_rdata.
    vld_d        = RD_LAT'({vld_q, mem_en});

    if (vld_q[RD_LAT-1]) begin
      if (32'(mem_rdata) > MAX_LEN) begin
        error_d    = 1'b1;
        err_code_d = 2'd2;
      end else if (mem_rdata != '0) begin
        for (int l = 1; l <= MAX_LEN; l++)
          if (32'(mem_rdata) == l) bl_count_d[l] = bl_count_q[l] + COUNT_BIT'(1);
        if (4'(mem_rdata) > max_len_q) max_len_d = 4'(mem_rdata);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          state_d      = S_READ;
          cnt_d        = '0;
          base_d       = base_addr;
          bl_count_d   = '0;
          next_code_d  = '0;
          code_d       = '0;
          busy_d       = 1'b1;
          error_d      = 1'b0;
          err_code_d   = 2'd0;
          incomplete_d = 1'b0;
          max_len_d    = '0;
        end
      end
      S_READ: begin
        cnt_d = cnt_q + TW'(1);
        if (cnt_q == TW'(NUM_SYMS - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + TW'(1);
        if (cnt_q == TW'(RD_LAT - 1)) begin
          state_d = S_CODE;
          cnt_d   = TW'(1);
        end
      end
      S_CODE: begin
        // cnt_q is the length L being processed; bl_count[0] is held at zero.
        for (int l = 1; l <= MAX_LEN; l++) begin
          if (32'(cnt_q) == l) begin
            cnt_prev = bl_count_q[l-1];
            cnt_cur  = bl_count_q[l];
          end
        end
        code_d = canon_step(code_q, cnt_prev);
        for (int l = 1; l <= MAX_LEN; l++)
          if (32'(cnt_q) == l) next_code_d[l] = code_d;
        if (over_sub(code_d, cnt_cur, cnt_q)) begin
          error_d = 1'b1;
          if (err_code_q != 2'd2) err_code_d = 2'd1;
        end
        cnt_d = cnt_q + TW'(1);
        if (cnt_q == TW'(MAX_LEN)) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        if (max_len_q == '0) begin
          error_d = 1'b1;
          if (err_code_q == 2'd0) err_code_d = 2'd3;
        end else if (!error_q &&
                     (SW'(next_code_q[MAX_LEN]) + SW'(bl_count_q[MAX_LEN])) < (SW'(1) << MAX_LEN)) begin
          incomplete_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    query_count = '0;
    query_code  = '0;
    for (int l = 1; l <= MAX_LEN; l++) begin
      if (32'(query_len) == l) begin
        query_count = bl_count_q[l];
        query_code  = next_code_q[l];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      vld_q        <= '0;
      bl_count_q   <= '0;
      next_code_q  <= '0;
      code_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 2'd0;
      incomplete_q <= 1'b0;
      max_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      vld_q        <= vld_d;
      bl_count_q   <= bl_count_d;
      next_code_q  <= next_code_d;
      code_q       <= code_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      incomplete_q <= incomplete_d;
      max_len_q    <= max_len_d;
    end
  end

endmodule

// File: tb/tb_huff_len_hist.sv
// Two instances (RD_LAT 1 and 3) fed the same runs; expected results come from
// a Kraft-sum reference model and are checked by a done-triggered monitor.
module tb_huff_len_hist;

  localparam int N = 8;
  localparam int M = 7;

  typedef struct packed {
    logic [7:0][8:0] cnt;
    logic [7:0][7:0] code;
    logic [3:0]      mx;
    logic            err;
    logic [1:0]      ec;
    logic            inc;
    logic [31:0]     st;
  } exp_t;

  logic       clock, reset, start;
  logic [8:0] base_addr;
  logic       mem_en [2];
  logic [8:0] mem_addr [2];
  logic [3:0] rdata [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       error_w [2];
  logic [1:0] ec_w [2];
  logic       inc_w [2];
  logic [3:0] maxl_w [2];
  logic [3:0] qlen [2];
  logic [8:0] qcnt [2];
  logic [7:0] qcode [2];
  logic [3:0] mon_qlen [2];
  logic [3:0] stim_qlen;
  logic       use_stim;

  logic [3:0] mem [512];
  logic [3:0] rp0;
  logic [3:0] rp1 [3];

  exp_t sbq0[$];
  exp_t sbq1[$];
  int   lens [8];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   checked [2] = '{0, 0};

  huff_len_hist #(.LEN_BIT(4), .MAX_LEN(M), .NUM_SYMS(N), .ADDR_BIT(9), .COUNT_BIT(9), .RD_LAT(1)) dut0 (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(rdata[0]),
    .busy(busy_w[0]), .done(done_w[0]), .error(error_w[0]), .err_code(ec_w[0]),
    .incomplete(inc_w[0]), .max_len(maxl_w[0]), .query_len(qlen[0]),
    .query_count(qcnt[0]), .query_code(qcode[0]));

  huff_len_hist #(.LEN_BIT(4), .MAX_LEN(M), .NUM_SYMS(N), .ADDR_BIT(9), .COUNT_BIT(9), .RD_LAT(3)) dut1 (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(rdata[1]),
    .busy(busy_w[1]), .done(done_w[1]), .error(error_w[1]), .err_code(ec_w[1]),
    .incomplete(inc_w[1]), .max_len(maxl_w[1]), .query_len(qlen[1]),
    .query_count(qcnt[1]), .query_code(qcode[1]));

  initial clock = 1'b0;
  always #20 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // RAM models; unread cycles return 15 so mis-tagged data shows up as a range error.
  always @(posedge clock) begin
    rp0    <= mem_en[0] ? mem[mem_addr[0]] : 4'hF;
    rp1[0] <= mem_en[1] ? mem[mem_addr[1]] : 4'hF;
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
  end
  assign rdata[0] = rp0;
  assign rdata[1] = rp1[2];
  assign qlen[0]  = use_stim ? stim_qlen : mon_qlen[0];
  assign qlen[1]  = use_stim ? stim_qlen : mon_qlen[1];

  // Reference: next_code[L] = sum_{l<L} count[l]*2^(L-l); Kraft sum decides oversubscribed/incomplete.
  function automatic exp_t model();
    exp_t e;
    int   cnt [8];
    bit   rng, ovr;
    int   s, kraft;
    e = '0;
    cnt = '{default: 0};
    rng = 0;
    ovr = 0;
    for (int i = 0; i < N; i++) begin
      if (lens[i] > M) rng = 1;
      else if (lens[i] > 0) begin
        cnt[lens[i]]++;
        if (lens[i] > int'(e.mx)) e.mx = 4'(lens[i]);
      end
    end
    for (int L = 1; L <= M; L++) begin
      s = 0;
      for (int l = 1; l < L; l++) s += cnt[l] << (L - l);
      e.code[L] = 8'(s);
      e.cnt[L]  = 9'(cnt[L]);
      if (s + cnt[L] > (1 << L)) ovr = 1;
    end
    kraft = 0;
    for (int l = 1; l <= M; l++) kraft += cnt[l] << (M - l);
    e.ec  = rng ? 2'd2 : ovr ? 2'd1 : (e.mx == 0) ? 2'd3 : 2'd0;
    e.err = (e.ec != 2'd0);
    e.inc = (e.ec == 2'd0) && (kraft < (1 << M));
    return e;
  endfunction

  task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s lane%0d: got %0d expected %0d", nm, g, act, expv);
    end
  endtask

  task automatic check_lane(input int g);
    exp_t e;
    bit   have;
    logic [31:0] ecnt, ecode;
    have = 0;
    e = '0;
    if (g == 0 && sbq0.size() > 0) begin e = sbq0.pop_front(); have = 1; end
    else if (g == 1 && sbq1.size() > 0) begin e = sbq1.pop_front(); have = 1; end
    if (!have) begin
      nvec++;
      nerr++;
      $display("FAIL unexpected_done lane%0d: got done expected none", g);
    end else begin
      chk(g, "latency", 32'(cyc) - e.st, 32'(N + ((g == 0) ? 1 : 3) + M + 1));
      chk(g, "busy_at_done", 32'(busy_w[g]), 32'd0);
      chk(g, "error", 32'(error_w[g]), 32'(e.err));
      chk(g, "err_code", 32'(ec_w[g]), 32'(e.ec));
      chk(g, "incomplete", 32'(inc_w[g]), 32'(e.inc));
      chk(g, "max_len", 32'(maxl_w[g]), 32'(e.mx));
      for (int l = 0; l <= M + 1; l++) begin
        mon_qlen[g] = 4'(l);
        #1;
        ecnt  = (l >= 1 && l <= M) ? 32'(e.cnt[l])  : 32'd0;
        ecode = (l >= 1 && l <= M) ? 32'(e.code[l]) : 32'd0;
        chk(g, $sformatf("count_L%0d", l), 32'(qcnt[g]), ecnt);
        chk(g, $sformatf("code_L%0d", l), 32'(qcode[g]), ecode);
      end
      checked[g]++;
    end
  endtask

  initial begin
    mon_qlen[0] = '0;
    mon_qlen[1] = '0;
    forever begin
      @(negedge clock);
      for (int g = 0; g < 2; g++) if (done_w[g]) check_lane(g);
    end
  end

  task automatic run(input int b, input bit poke);
    exp_t e;
    int   t0, t1;
    bit   ok;
    for (int i = 0; i < N; i++) mem[(b + i) % 512] = 4'(lens[i]);
    e  = model();
    t0 = checked[0];
    t1 = checked[1];
    @(negedge clock);
    base_addr = 9'(b);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    e.st = 32'(cyc);
    sbq0.push_back(e);
    sbq1.push_back(e);
    if (poke) begin
      repeat (5) @(negedge clock);
      base_addr = 9'(b + 37);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    ok = 0;
    for (int c = 0; c < 80 && !ok; c++) begin
      @(negedge clock);
      if (checked[0] > t0 && checked[1] > t1) ok = 1;
    end
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL run_complete: got no done within 80 cycles expected done at base %0d", b);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic check_idle(input string tag);
    use_stim  = 1'b1;
    stim_qlen = 4'd3;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk(g, {tag, "_mem_en"}, 32'(mem_en[g]), 32'd0);
      chk(g, {tag, "_mem_addr"}, 32'(mem_addr[g]), 32'd0);
      chk(g, {tag, "_busy"}, 32'(busy_w[g]), 32'd0);
      chk(g, {tag, "_done"}, 32'(done_w[g]), 32'd0);
      chk(g, {tag, "_error"}, 32'(error_w[g]), 32'd0);
      chk(g, {tag, "_err_code"}, 32'(ec_w[g]), 32'd0);
      chk(g, {tag, "_incomplete"}, 32'(inc_w[g]), 32'd0);
      chk(g, {tag, "_max_len"}, 32'(maxl_w[g]), 32'd0);
      chk(g, {tag, "_qcount"}, 32'(qcnt[g]), 32'd0);
      chk(g, {tag, "_qcode"}, 32'(qcode[g]), 32'd0);
    end
    use_stim = 1'b0;
  endtask

  initial begin
    int mode;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    use_stim = 1'b1;
    stim_qlen = '0;
    for (int i = 0; i < 512; i++) mem[i] = 4'(i);
    repeat (3) @(negedge clock);
    check_idle("reset");
    reset = 1'b0;

    lens = '{3, 3, 3, 3, 3, 2, 4, 4};  run(10, 0);
    lens = '{1, 1, 1, 0, 0, 0, 0, 0};  run(100, 0);
    lens = '{9, 2, 2, 0, 0, 0, 0, 0};  run(200, 0);
    lens = '{1, 1, 1, 0, 0, 0, 0, 0};  run(300, 0);
    lens = '{0, 0, 0, 0, 0, 0, 0, 0};  run(400, 0);
    lens = '{1, 0, 0, 0, 0, 0, 0, 0};  run(508, 0);
    lens = '{3, 3, 3, 3, 3, 2, 4, 4};  run(20, 1);

    // Abort a run in READ: everything must be back to zero one edge later.
    for (int i = 0; i < N; i++) mem[(250 + i) % 512] = 4'(lens[i]);
    @(negedge clock);
    base_addr = 9'd250;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_idle("midreset");
    reset = 1'b0;
    repeat (2) @(negedge clock);
    run(30, 0);

    for (int r = 0; r < 24; r++) begin
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        case (mode)
          0:       lens[i] = int'($urandom_range(0, 7));
          1:       lens[i] = int'($urandom_range(0, 3));
          2:       lens[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
          default: lens[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 15))
                                                         : int'($urandom_range(2, 4));
        endcase
      end
      run(int'($urandom_range(0, 511)), (r % 5) == 0);
    end

    repeat (30) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/huff_len_hist.md
Name: huff_len_hist

Overview:
- Next-generation code-length counter for the Deflate decompressor.
- Reads NUM_SYMS code lengths from a block RAM with configurable read latency, builds the per-length histogram (bl_count), and computes canonical first codes (next_code) for lengths 1..MAX_LEN.
- Validates the code: length range, over-subscription, empty code, incomplete code.
- Sits between the code-length RAM and the Huffman table builder, which reads results through a query port.

Parameters:
- LEN_BIT, 4, width of one stored code length.
- MAX_LEN, 15, largest legal code length; lengths above it are errors.
- NUM_SYMS, 19, symbols read per run.
- ADDR_BIT, 9, RAM address width.
- COUNT_BIT, 9, histogram counter width; must satisfy 2^COUNT_BIT > NUM_SYMS.
- RD_LAT, 1, RAM read latency in cycles, ≥1.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, run request; sampled only in IDLE.
- base_addr, in, ADDR_BIT, address of symbol 0; captured on accepted start.
- mem_en, out, 1, RAM read enable.
- mem_addr, out, ADDR_BIT, RAM read address.
- mem_rdata, in, LEN_BIT, RAM data, valid RD_LAT cycles after the enabled address.
- busy, out, 1, high from accepted start until done.
- done, out, 1, one-cycle completion pulse.
- error, out, 1, sticky error flag for the last run.
- err_code, out, 2, 0 none, 1 over-subscribed, 2 length>MAX_LEN, 3 empty (all zero).
- incomplete, out, 1, code is valid but not full (Kraft sum < 1).
- max_len, out, 4, largest nonzero in-range length seen.
- query_len, in, 4, length to query.
- query_count, out, COUNT_BIT, bl_count[query_len].
- query_code, out, MAX_LEN+1, next_code[query_len].

Behaviour:
- Reset values: all outputs 0; histogram and next_code arrays 0; state IDLE; internal read pipeline cleared. Reset mid-run aborts immediately, and mem_en is 0 after the reset edge.
- States: IDLE -> READ -> DRAIN -> CODE -> FIN -> IDLE.
- IDLE: start=1 on an edge is accepted:
  - histogram, next_code, error, err_code, incomplete and max_len clear;
  - busy goes to 1;
  - go to READ.
- READ: NUM_SYMS cycles. mem_en=1, mem_addr = base_addr + i for i = 0..NUM_SYMS-1, one address per cycle. Then DRAIN.
- DRAIN: RD_LAT cycles with mem_en=0, collecting the remaining data. Then CODE.
- Data capture: a RD_LAT-deep valid shift register tags returning data. For each valid length v:
  - v=0: ignored;
  - 1 ≤ v ≤ MAX_LEN: bl_count[v]++, and max_len = max(max_len, v);
  - v > MAX_LEN: error=1 and the value is not counted.
- CODE: MAX_LEN cycles, L = 1..MAX_LEN, one length per cycle. Code registers are MAX_LEN+1 bits wide.
  - code = (code + bl_count[L-1]) << 1, with bl_count[0] treated as 0 and code starting at 0.
  - next_code[L] = code.
  - If code + bl_count[L] > 2^L, the code is over-subscribed: error=1.
- FIN: one cycle.
  - If no nonzero in-range length was seen: empty condition, error=1.
  - Else if no error and next_code[MAX_LEN] + bl_count[MAX_LEN] < 2^MAX_LEN: incomplete=1. This is not an error; single-code trees are legal.
  - done=1 and busy=0 on the same edge; return to IDLE.
- err_code priority: 2 > 1 > 3. When several errors occur, the highest-priority one is reported. On error, processing still runs to FIN, so the done timing is fixed.
- Latency: done is high exactly NUM_SYMS + RD_LAT + MAX_LEN + 1 cycles after the start-accept edge.
- start while busy is ignored. start in the same cycle as done is not accepted; it is accepted the following cycle if still high.
- Query port:
  - combinational from registers;
  - query_len = 0 or > MAX_LEN returns 0 on both outputs;
  - values are stable from done until the next accepted start; during a run they are don't-care.

Test Plan:
- NUM_SYMS=8, MAX_LEN=7, lengths {3,3,3,3,3,2,4,4}:
  - counts: L2=1, L3=5, L4=2;
  - next_code: L2=0, L3=2, L4=14, L5=32;
  - max_len=4, error=0, incomplete=0;
  - done exactly 8+RD_LAT+7+1 cycles after start.
- Lengths {1,1,1,0,0,0,0,0}: L1 check 0+3>2 -> error=1, err_code=1, done at nominal latency.
- LEN_BIT=4, MAX_LEN=7, lengths {9,2,2,0,...} plus over-subscription {1,1,1} in a second run: run1 gives err_code=2 with count L2=2 and length 9 not counted; run2 gives err_code=1 and verifies that error state is cleared per run.
- All zeros -> err_code=3, max_len=0. Single symbol of length 1, rest zero -> error=0, incomplete=1, next_code L1=0.
- Reset asserted mid-READ -> mem_en=0, busy=0, outputs 0 next cycle; a start pulsed during busy is ignored; RD_LAT=3 rerun of the first scenario gives identical results and done latency +2.
